// File: rtl/next_pc_pkg.sv
// rtl/next_pc_pkg.sv - shared widths, constants and PC type for next-PC selection
package next_pc_pkg;

  localparam int          PC_WIDTH     = 64;
  localparam logic [63:0] PC_INCR      = 64'd4;
  localparam int          OFFSET_SHIFT = 2;
  localparam int          COUNT_WIDTH  = 32;

  typedef logic [63:0] pc_t;

endpackage

// File: rtl/next_pc_target_adder.sv
// rtl/next_pc_target_adder.sv - branch target: CurrentPC plus word offset scaled to bytes
module next_pc_target_adder
  import next_pc_pkg::*;
(
  input  logic [PC_WIDTH-1:0] CurrentPC,
  input  logic [PC_WIDTH-1:0] SignExtImm64,
  output logic [PC_WIDTH-1:0] Target
);

  logic [PC_WIDTH-1:0] byte_offset;

  // Shift drops the top two offset bits; the add wraps modulo 2^64.
  assign byte_offset = SignExtImm64 << OFFSET_SHIFT;
  assign Target      = CurrentPC + byte_offset;

endmodule

// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - next-PC select mux, PC register, optional taken counter (NEXTPC_STATS_EN)
module next_pc_logic
  import next_pc_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 64'd0
)
(
  input  logic                   CLK,
  input  logic                   Reset_L,
  input  logic [PC_WIDTH-1:0]    CurrentPC,
  input  logic [PC_WIDTH-1:0]    SignExtImm64,
  input  logic                   Branch,
  input  logic                   ALUZero,
  input  logic                   Uncondbranch,
  input  logic                   PCWrite,
  output logic [PC_WIDTH-1:0]    NextPC,
  output logic                   BranchTaken,
  output logic [PC_WIDTH-1:0]    PC
`ifdef NEXTPC_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] TakenCount
`endif
);

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] sequential;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  next_pc_target_adder u_target_adder (
    .CurrentPC    (CurrentPC),
    .SignExtImm64 (SignExtImm64),
    .Target       (target)
  );

  assign sequential  = CurrentPC + PC_INCR;
  // Plain operators so X/Z on the controls propagates instead of defaulting to sequential.
  assign BranchTaken = Uncondbranch | (Branch & ALUZero);
  assign NextPC      = BranchTaken ? target : sequential;

  always_comb begin
    pc_d = pc_q;
    if (PCWrite) begin
      pc_d = NextPC;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

`ifdef NEXTPC_STATS_EN
  logic [COUNT_WIDTH-1:0] count_d;
  logic [COUNT_WIDTH-1:0] count_q;

  // Saturating: sticks at all-ones rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (PCWrite && BranchTaken && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign TakenCount = count_q;
`endif

endmodule

// File: tb/tb_next_pc_logic.sv
// tb/tb_next_pc_logic.sv - scoreboard bench for next_pc_logic (TakenCount checks under NEXTPC_STATS_EN)
module tb_next_pc_logic;
  import next_pc_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset_L;
  pc_t         CurrentPC;
  pc_t         SignExtImm64;
  logic        Branch;
  logic        ALUZero;
  logic        Uncondbranch;
  logic        PCWrite;
  pc_t         NextPC;
  logic        BranchTaken;
  pc_t         PC;
`ifdef NEXTPC_STATS_EN
  logic [31:0] TakenCount;
`endif

  next_pc_logic dut (
    .CLK          (CLK),
    .Reset_L      (Reset_L),
    .CurrentPC    (CurrentPC),
    .SignExtImm64 (SignExtImm64),
    .Branch       (Branch),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .PCWrite      (PCWrite),
    .NextPC       (NextPC),
    .BranchTaken  (BranchTaken),
    .PC           (PC)
`ifdef NEXTPC_STATS_EN
    ,
    .TakenCount   (TakenCount)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] comb_q[$];
  pc_t         pc_q[$];
  pc_t         pc_m;
  logic [31:0] cnt_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input pc_t cur, input pc_t imm,
                                         input logic br, input logic z, input logic ub);
    logic taken;
    pc_t  nxt;
    taken = ub | (br & z);
    nxt   = taken ? (cur + imm * 64'd4) : (cur + 64'd4);
    return {taken, nxt};
  endfunction

  task automatic drive(input pc_t cur, input pc_t imm, input logic br, input logic z, input logic ub);
    CurrentPC    = cur;
    SignExtImm64 = imm;
    Branch       = br;
    ALUZero      = z;
    Uncondbranch = ub;
  endtask

  task automatic comb_case(input string tag, input pc_t cur, input pc_t imm,
                           input logic br, input logic z, input logic ub);
    logic [64:0] exp;
    drive(cur, imm, br, z, ub);
    comb_q.push_back(model(cur, imm, br, z, ub));
    #1;
    if (comb_q.size() == 0) begin
      check({tag, "_empty"}, 64'd1, 64'd0);
    end else begin
      exp = comb_q.pop_front();
      check({tag, "_npc"}, NextPC, exp[63:0]);
      check({tag, "_taken"}, {63'd0, BranchTaken}, {63'd0, exp[64]});
    end
  endtask

  task automatic clk_step(input string tag, input pc_t cur, input pc_t imm, input logic br,
                          input logic z, input logic ub, input logic wr);
    logic [64:0] m;
    @(negedge CLK);
    drive(cur, imm, br, z, ub);
    PCWrite = wr;
    m = model(cur, imm, br, z, ub);
    if (wr) begin
      pc_m = m[63:0];
      if (m[64] && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
    end
    pc_q.push_back(pc_m);
    @(posedge CLK);
    #1;
    check({tag, "_pc"}, PC, pc_q.pop_front());
`ifdef NEXTPC_STATS_EN
    check({tag, "_cnt"}, {32'd0, TakenCount}, {32'd0, cnt_m});
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset_L = 1'b0;
    PCWrite = 1'b0;
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    pc_m  = 64'd0;
    cnt_m = 32'd0;
    #2;
    check("reset_pc", PC, 64'd0);
`ifdef NEXTPC_STATS_EN
    check("reset_cnt", {32'd0, TakenCount}, 64'd0);
`endif

    @(negedge CLK);
    Reset_L = 1'b1;
    clk_step("load_seq",   64'd8,   64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    clk_step("stall_hold", 64'd100, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clk_step("taken_b",    64'd180, 64'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    clk_step("taken_cbz",  64'd192, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, 1'b0, 1'b1);
    clk_step("taken_stall",64'd180, 64'd5, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a cycle with a load pending
    @(posedge CLK);
    drive(64'd400, 64'd0, 1'b0, 1'b0, 1'b1);
    PCWrite = 1'b1;
    #3;
    Reset_L = 1'b0;
    #1;
    check("midreset_pc", PC, 64'd0);
`ifdef NEXTPC_STATS_EN
    check("midreset_cnt", {32'd0, TakenCount}, 64'd0);
`endif
    @(posedge CLK);
    #1;
    check("reset_held_pc", PC, 64'd0);
    PCWrite = 1'b0;

    comb_case("zero_seq",   64'd0,   64'd0, 1'b0, 1'b0, 1'b0);
    comb_case("uncond_fwd", 64'd180, 64'd3, 1'b0, 1'b0, 1'b1);
    comb_case("cbz_taken",  64'd180, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, 1'b0);
    comb_case("cbz_not",    64'd180, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b0);
    comb_case("zero_only",  64'd180, 64'd7, 1'b0, 1'b1, 1'b0);
    comb_case("uncond_pri", 64'd180, 64'd2, 1'b1, 1'b0, 1'b1);
    comb_case("wrap_seq",   64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 1'b0, 1'b0);
    comb_case("wrap_tgt",   64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 1'b0, 1'b0, 1'b1);
    comb_case("imm_topdrop",64'd100, 64'hC000_0000_0000_0001, 1'b0, 1'b0, 1'b1);
    comb_case("unaligned",  64'd183, 64'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      comb_case("random", {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/next_pc_logic.md
# next_pc_logic

Next-program-counter selection for the single-cycle 64-bit ARM-style datapath. It sits between the instruction decode/ALU stage and the PC register. It computes the sequential or branch-target address combinationally from the current PC, the sign-extended word offset and the branch controls. It also owns the architectural PC register, which loads the selected address each clock.

## Interface
- RESET_PC, 64'd0, value loaded into the PC register on reset.
- CLK  input  1  system clock; all state updates on its rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- CurrentPC  input  64  address of the instruction currently executing.
- SignExtImm64  input  64  sign-extended branch offset, in instruction words (not bytes).
- Branch  input  1  conditional branch (CBZ) decoded.
- ALUZero  input  1  ALU zero flag for the CBZ operand.
- Uncondbranch  input  1  unconditional branch (B) decoded.
- PCWrite  input  1  PC register load enable; 0 = stall, hold value.
- NextPC  output  64  combinational next address.
- BranchTaken  output  1  combinational; 1 when NextPC is the branch target.
- PC  output  64  registered architectural PC.
- TakenCount  output  32  registered taken-branch counter; present only with NEXTPC_STATS_EN.

## Operation
- BranchTaken = Uncondbranch | (Branch & ALUZero).
- Target = CurrentPC + (SignExtImm64 << 2), modulo 2^64. The shift discards the top two offset bits. The sum is two's-complement, so negative offsets branch backward.
- Sequential = CurrentPC + 4, modulo 2^64. At CurrentPC = 64'hFFFF_FFFF_FFFF_FFFC it wraps to 0.
- NextPC = BranchTaken ? Target : Sequential.
- Uncondbranch takes priority. With Uncondbranch = 1, Branch and ALUZero are don't-cares.
- Branch = 1 with ALUZero = 0 gives Sequential.
- ALUZero alone, with Branch = 0 and Uncondbranch = 0, gives Sequential.
- There is no alignment checking. Low two bits of CurrentPC propagate unchanged.
- X/Z on any control input must not be masked: no default-to-sequential coercion.

## Timing
- NextPC and BranchTaken are purely combinational: zero-cycle latency from any input. They are independent of CLK and Reset_L.
- PC behaviour:
  - Reset_L low asynchronously forces PC = RESET_PC and TakenCount = 0, regardless of CLK.
  - Rising CLK with Reset_L high and PCWrite = 1: PC <= NextPC.
  - PCWrite = 0: PC holds.
  - Reset deassertion is synchronised externally. The first load occurs on the first rising CLK after Reset_L goes high.
- Reset asserted mid-operation discards any pending load. No cycle is replayed.
- No handshake and no state machine.

## Configuration
- Macro: NEXTPC_STATS_EN.
- Defined:
  - TakenCount port exists.
  - It increments by 1 on rising CLK when PCWrite & BranchTaken.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - Reset value is 0.
- Undefined: TakenCount port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package next_pc_pkg:
  - PC_WIDTH = 64
  - PC_INCR = 64'd4
  - OFFSET_SHIFT = 2
  - COUNT_WIDTH = 32
  - typedef pc_t (logic [63:0])
- Sub-module next_pc_target_adder computes Target from CurrentPC and SignExtImm64, purely combinationally.
- The top level holds the select mux, the PC register and the optional counter.

## Test plan
- CurrentPC = 0, SignExtImm64 = 0, Branch/ALUZero/Uncondbranch = 000 -> NextPC = 4, BranchTaken = 0.
- CurrentPC = 180, SignExtImm64 = 3, Uncondbranch = 1 (Branch = 0, ALUZero = 0) -> NextPC = 192, BranchTaken = 1.
- CurrentPC = 180, SignExtImm64 = -3, Branch = 1, ALUZero = 1 -> NextPC = 168 (CBZ taken).
- CurrentPC = 180, SignExtImm64 = -3, Branch = 1, ALUZero = 0 -> NextPC = 184 (CBZ not taken).
- CurrentPC = 64'hFFFF_FFFF_FFFF_FFFC, no branch -> NextPC = 0. Then Uncondbranch = 1, SignExtImm64 = 1 -> NextPC = 0.
- PC register sequence:
  - Reset_L low mid-cycle -> PC = RESET_PC immediately.
  - Release reset; drive CurrentPC = 8 with PCWrite = 1 -> PC = 12 after one CLK edge.
  - PCWrite = 0 -> PC holds 12.
  - With NEXTPC_STATS_EN, two taken edges with PCWrite = 1 -> TakenCount = 2.
  - A taken edge with PCWrite = 0 -> TakenCount unchanged.
